// File: rtl/ddr_sref_sequencer.sv
// N-channel DDR4 self-refresh save/restore sequencer: drives the MIG sref handshake
// before partial reconfiguration and the init-skip/calibration/restore sequence after it.
module ddr_sref_sequencer #(
  parameter int NUM_CH        = 3,
  parameter int ACK_TIMEOUT   = 65535,
  parameter int CALIB_TIMEOUT = 1048575,
  parameter int RESTORE_HOLD  = 16
) (
  input  logic                  sys_clk,
  input  logic                  rst_main_n,
  input  logic [NUM_CH-1:0]     ch_enable,
  input  logic                  sref_enter,
  input  logic                  sref_exit,
  input  logic [NUM_CH-1:0]     app_sref_ack,
  input  logic [NUM_CH-1:0]     init_calib_complete,
  output logic [NUM_CH-1:0]     app_sref_req,
  output logic [NUM_CH-1:0]     app_mem_init_skip,
  output logic [NUM_CH-1:0]     app_xsdb_select,
  output logic [NUM_CH-1:0]     app_restore_complete,
  output logic [8*NUM_CH-1:0]   ctrl_status,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ENTER     = 3'd1,
    IN_SREF   = 3'd2,
    EXIT_WAIT = 3'd3,
    RESTORE   = 3'd4,
    ERR       = 3'd5
  } state_t;

  localparam int MAX_AC = (ACK_TIMEOUT > CALIB_TIMEOUT) ? ACK_TIMEOUT : CALIB_TIMEOUT;
  localparam int MAX_T  = (MAX_AC > RESTORE_HOLD) ? MAX_AC : RESTORE_HOLD;
  localparam int CW     = $clog2(MAX_T + 1);

  // Limits are one less than the timeout because the counter starts at 0 on state entry.
  localparam logic [CW-1:0] ACK_LIM   = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] CALIB_LIM = CW'(CALIB_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LIM  = CW'(RESTORE_HOLD - 1);

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [NUM_CH-1:0]   en, en_nxt;
  logic [NUM_CH-1:0]   ackl, ackl_nxt;
  logic [NUM_CH-1:0]   tmo, tmo_nxt;
  logic                error_nxt, done_nxt;
  logic [NUM_CH-1:0]   req_nxt, skip_nxt, xsdb_nxt, rc_nxt;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    en_nxt    = en;
    ackl_nxt  = ackl;
    tmo_nxt   = tmo;
    error_nxt = error;
    done_nxt  = 1'b0;
    req_nxt   = '0;
    skip_nxt  = '0;
    xsdb_nxt  = '0;
    rc_nxt    = '0;

    unique case (state)
      IDLE: begin
        if (sref_enter) begin
          state_nxt = ENTER;
          en_nxt    = ch_enable;
          ackl_nxt  = '0;
          tmo_nxt   = '0;
          error_nxt = 1'b0;
          req_nxt   = ch_enable;
        end
      end
      ENTER: begin
        ackl_nxt = ackl | (app_sref_ack & en);
        req_nxt  = en;
        // Disabled channels count as acknowledged; an ack on the final counted cycle still wins.
        if (&(ackl_nxt | ~en)) begin
          state_nxt = IN_SREF;
          done_nxt  = 1'b1;
          skip_nxt  = en;
          xsdb_nxt  = en;
        end else if (cnt >= ACK_LIM) begin
          state_nxt = ERR;
          tmo_nxt   = en & ~ackl_nxt;
          error_nxt = 1'b1;
          done_nxt  = 1'b1;
          req_nxt   = '0;
        end
      end
      IN_SREF: begin
        req_nxt  = en;
        skip_nxt = en;
        xsdb_nxt = en;
        if (sref_exit) begin
          state_nxt = EXIT_WAIT;
          req_nxt   = '0;
        end
      end
      EXIT_WAIT: begin
        skip_nxt = en;
        xsdb_nxt = en;
        if (&(init_calib_complete | ~en)) begin
          state_nxt = RESTORE;
          rc_nxt    = en;
        end else if (cnt >= CALIB_LIM) begin
          state_nxt = ERR;
          tmo_nxt   = en & ~init_calib_complete;
          error_nxt = 1'b1;
          done_nxt  = 1'b1;
          skip_nxt  = '0;
          xsdb_nxt  = '0;
        end
      end
      RESTORE: begin
        skip_nxt = en;
        xsdb_nxt = en;
        rc_nxt   = en;
        if (cnt >= HOLD_LIM) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          skip_nxt  = '0;
          xsdb_nxt  = '0;
          rc_nxt    = '0;
        end
      end
      ERR: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Counter restarts on every state change and saturates rather than wrapping.
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else if (cnt != '1) begin
      cnt_nxt = cnt + CW'(1);
    end else begin
      cnt_nxt = cnt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (!rst_main_n) begin
      state                <= IDLE;
      cnt                  <= '0;
      en                   <= '0;
      ackl                 <= '0;
      tmo                  <= '0;
      error                <= 1'b0;
      done                 <= 1'b0;
      app_sref_req         <= '0;
      app_mem_init_skip    <= '0;
      app_xsdb_select      <= '0;
      app_restore_complete <= '0;
    end else begin
      state                <= state_nxt;
      cnt                  <= cnt_nxt;
      en                   <= en_nxt;
      ackl                 <= ackl_nxt;
      tmo                  <= tmo_nxt;
      error                <= error_nxt;
      done                 <= done_nxt;
      app_sref_req         <= req_nxt;
      app_mem_init_skip    <= skip_nxt;
      app_xsdb_select      <= xsdb_nxt;
      app_restore_complete <= rc_nxt;
    end
  end

  always_comb begin
    ctrl_status = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ctrl_status[8*c +: 8] = {ackl[c], tmo[c], en[c] & (state == IN_SREF), app_xsdb_select[c],
                               app_mem_init_skip[c], app_restore_complete[c], en[c], app_sref_req[c]};
    end
  end

  assign busy    = (state != IDLE);
  assign state_o = state;

endmodule

// File: tb/tb_ddr_sref_sequencer.sv
// Directed bench for ddr_sref_sequencer: instance a covers the main flows,
// instance b (shorter calibration timeout) covers the calibration-timeout path.
module tb_ddr_sref_sequencer;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  ch_enable;
  logic          sref_enter, sref_exit;
  logic [N-1:0]  ack, calib;

  logic [N-1:0]   a_req, a_skip, a_xsdb, a_rc;
  logic [8*N-1:0] a_status;
  logic           a_busy, a_done, a_error;
  logic [2:0]     a_state;

  logic [N-1:0]   b_req, b_skip, b_xsdb, b_rc;
  logic [8*N-1:0] b_status;
  logic           b_busy, b_done, b_error;
  logic [2:0]     b_state;

  int checks = 0;
  int errors = 0;
  int rc_cycles;

  always #5 clk = ~clk;

  ddr_sref_sequencer #(.NUM_CH(N), .ACK_TIMEOUT(20), .CALIB_TIMEOUT(60), .RESTORE_HOLD(16)) dut_a (
    .sys_clk(clk), .rst_main_n(rst_n), .ch_enable(ch_enable), .sref_enter(sref_enter),
    .sref_exit(sref_exit), .app_sref_ack(ack), .init_calib_complete(calib),
    .app_sref_req(a_req), .app_mem_init_skip(a_skip), .app_xsdb_select(a_xsdb),
    .app_restore_complete(a_rc), .ctrl_status(a_status), .busy(a_busy), .done(a_done),
    .error(a_error), .state_o(a_state)
  );

  ddr_sref_sequencer #(.NUM_CH(N), .ACK_TIMEOUT(20), .CALIB_TIMEOUT(30), .RESTORE_HOLD(16)) dut_b (
    .sys_clk(clk), .rst_main_n(rst_n), .ch_enable(ch_enable), .sref_enter(sref_enter),
    .sref_exit(sref_exit), .app_sref_ack(ack), .init_calib_complete(calib),
    .app_sref_req(b_req), .app_mem_init_skip(b_skip), .app_xsdb_select(b_xsdb),
    .app_restore_complete(b_rc), .ctrl_status(b_status), .busy(b_busy), .done(b_done),
    .error(b_error), .state_o(b_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ch_enable = '0; sref_enter = 1'b0; sref_exit = 1'b0; ack = '0; calib = '0;
    repeat (3) tick();
    check("rst_state", a_state, 0);
    check("rst_req", a_req, 0);
    check("rst_status", a_status, 0);
    check("rst_flags", {a_busy, a_done, a_error}, 0);
    rst_n = 1'b1;
    tick();

    // Exit while idle is ignored.
    sref_exit = 1'b1; tick(); sref_exit = 1'b0;
    check("exit_in_idle", a_state, 0);

    // Full enable, acks at 5 (pulse only) / 9 / 12.
    ch_enable = 3'b111; sref_enter = 1'b1; tick(); sref_enter = 1'b0;
    check("t1_enter_state", a_state, 1);
    check("t1_req", a_req, 3'b111);
    check("t1_busy", a_busy, 1);
    for (int k = 1; k <= 12; k++) begin
      ack = {k >= 12, k >= 9, k == 5};
      tick();
      if (k == 11) check("t1_still_enter", a_state, 1);
      if (k == 11) check("t1_no_done", a_done, 0);
    end
    check("t1_in_sref", a_state, 2);
    check("t1_done", a_done, 1);
    check("t1_status", a_status, 24'hBBBBBB);
    ack = '0; sref_enter = 1'b1; tick(); sref_enter = 1'b0;
    check("t1_enter_ignored", a_state, 2);
    check("t1_done_pulse", a_done, 0);

    // Exit: calib at 30 / 40 / 50, restore held exactly 16 cycles.
    sref_exit = 1'b1; tick(); sref_exit = 1'b0;
    check("t4_exit_state", a_state, 3);
    check("t4_req_drop", a_req, 0);
    check("t4_skip", {a_skip, a_xsdb}, 6'b111111);
    rc_cycles = 0;
    for (int k = 1; k <= 66; k++) begin
      calib = {k >= 50, k >= 40, k >= 30};
      tick();
      if (a_rc == 3'b111) rc_cycles++;
      if (k == 49) check("t4_wait49", a_state, 3);
      if (k == 50) check("t4_restore50", a_state, 4);
      if (k == 65) check("t4_rc65", a_rc, 3'b111);
    end
    check("t4_rc_len", rc_cycles, 16);
    check("t4_idle", a_state, 0);
    check("t4_done", a_done, 1);
    check("t4_app_zero", {a_req, a_skip, a_xsdb, a_rc}, 0);
    calib = '0; tick();
    check("t4_done_pulse", a_done, 0);

    // Partial enable 101: ch1 ack ignored, ch1 status stays zero.
    ch_enable = 3'b101; sref_enter = 1'b1; tick(); sref_enter = 1'b0;
    check("t2_req", a_req, 3'b101);
    for (int k = 1; k <= 6; k++) begin
      ack = {k >= 6, 1'b1, k >= 3};
      tick();
      if (k == 5) check("t2_still_enter", a_state, 1);
    end
    check("t2_in_sref", a_state, 2);
    check("t2_status", a_status, 24'hBB00BB);
    ack = '0;
    sref_exit = 1'b1; tick(); sref_exit = 1'b0;
    calib = 3'b101; tick();
    check("t2_restore", a_state, 4);
    check("t2_rc", a_rc, 3'b101);
    repeat (16) tick();
    check("t2_idle", a_state, 0);
    calib = '0;

    // Ack timeout: ch2 never acks.
    ch_enable = 3'b111; sref_enter = 1'b1; tick(); sref_enter = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      ack = {1'b0, k >= 3, k >= 2};
      tick();
      if (k == 19) check("t3_enter19", a_state, 1);
    end
    check("t3_err_state", a_state, 5);
    check("t3_error", a_error, 1);
    check("t3_done", a_done, 1);
    check("t3_req", a_req, 0);
    check("t3_status", a_status, 24'h428282);
    ack = '0; tick();
    check("t3_idle", a_state, 0);
    check("t3_sticky", a_error, 1);

    // Next enter clears error; no channels enabled completes ENTER in one cycle.
    ch_enable = 3'b000; sref_enter = 1'b1; tick(); sref_enter = 1'b0;
    check("t5_err_clear", a_error, 0);
    check("t5_enter", a_state, 1);
    tick();
    check("t5_in_sref", a_state, 2);
    check("t5_done", a_done, 1);
    sref_exit = 1'b1; tick(); sref_exit = 1'b0;
    repeat (17) tick();
    check("t5_idle", a_state, 0);
    check("t5_done_end", a_done, 1);

    // Enter and exit together: enter wins; then reset mid EXIT_WAIT.
    ch_enable = 3'b111; sref_enter = 1'b1; sref_exit = 1'b1; tick();
    sref_enter = 1'b0; sref_exit = 1'b0;
    check("s_both_enter", a_state, 1);
    ack = 3'b111; tick();
    check("s_in_sref", a_state, 2);
    ack = '0; sref_exit = 1'b1; tick(); sref_exit = 1'b0;
    repeat (4) tick();
    check("s_exit_wait", a_state, 3);
    rst_n = 1'b0; tick();
    check("s_rst_state", a_state, 0);
    check("s_rst_app", {a_req, a_skip, a_xsdb, a_rc}, 0);
    check("s_rst_status", a_status, 0);
    check("s_rst_busy", a_busy, 0);
    rst_n = 1'b1; tick();

    // Calibration timeout on instance b: ch1 never calibrates.
    check("b_idle", b_state, 0);
    sref_enter = 1'b1; tick(); sref_enter = 1'b0;
    ack = 3'b111; tick(); ack = '0;
    check("b_in_sref", b_state, 2);
    sref_exit = 1'b1; tick(); sref_exit = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      calib = 3'b101;
      tick();
      if (k == 29) check("b_wait29", b_state, 3);
    end
    check("b_err_state", b_state, 5);
    check("b_error", b_error, 1);
    check("b_done", b_done, 1);
    check("b_status", b_status, 24'h82C282);
    check("b_app_zero", {b_req, b_skip, b_xsdb, b_rc}, 0);
    tick();
    check("b_idle_after", b_state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr_sref_sequencer.md
Name: ddr_sref_sequencer

Overview:
- Parametrised N-channel DDR4 self-refresh save/restore sequencer in the static shell.
- Replaces per-channel software bit-banging of the 8-bit SREF control words.
- Sequences sref_req/ack entry before partial reconfiguration, then mem_init_skip, calibration wait and restore_complete on exit.
- Reports per-channel status in the existing 8-bit SREF_CTRL_IN layout.

Parameters:
NUM_CH, 3, number of MIG channels sequenced.
ACK_TIMEOUT, 65535, max cycles to wait for all sref_ack after request.
CALIB_TIMEOUT, 1048575, max cycles to wait for all init_calib_complete on exit.
RESTORE_HOLD, 16, cycles app_restore_complete is held high (≥1).

Ports:
sys_clk  in  1  single clock for all logic.
rst_main_n  in  1  synchronous active-low reset.
ch_enable  in  NUM_CH  channels participating; sampled on accepted sref_enter.
sref_enter  in  1  single-cycle command: enter self-refresh.
sref_exit  in  1  single-cycle command: exit/restore.
app_sref_ack  in  NUM_CH  per-channel MIG self-refresh acknowledge.
init_calib_complete  in  NUM_CH  per-channel MIG calibration done.
app_sref_req  out  NUM_CH  per-channel self-refresh request.
app_mem_init_skip  out  NUM_CH  skip memory init on recalibration.
app_xsdb_select  out  NUM_CH  restore calibration data path select.
app_restore_complete  out  NUM_CH  restore finished indication to MIG.
ctrl_status  out  8*NUM_CH  per channel c, bits [8c+7:8c]:
  - [7] ack latched
  - [6] timeout flag
  - [5] in self-refresh
  - [4] xsdb_select
  - [3] mem_init_skip
  - [2] restore_complete
  - [1] channel enabled
  - [0] sref_req
busy  out  1  high whenever state != IDLE.
done  out  1  one-cycle pulse on every sequence completion (success or error).
error  out  1  sticky timeout flag; cleared only by the next accepted sref_enter or by reset.
state_o  out  3  encoded state: IDLE=0, ENTER=1, IN_SREF=2, EXIT_WAIT=3, RESTORE=4, ERR=5.

Behaviour:
- Reset (rst_main_n low at a sys_clk edge):
  - all outputs 0; state IDLE; counters, latched ack and enable cleared.
  - reset mid-sequence aborts immediately and drops sref_req without handshake.
- IDLE:
  - sref_enter → latch en = ch_enable, clear ack latches, timeout flags and error → ENTER.
  - sref_exit in IDLE is ignored.
  - simultaneous enter and exit: enter wins.
- ENTER:
  - app_sref_req = en (registered, asserted the cycle after entry).
  - ack latch[c] sets when app_sref_ack[c] is high; a later drop of ack is ignored.
  - Disabled channels count as acked.
  - All latches set → IN_SREF, with done pulse.
  - Counter reaches ACK_TIMEOUT first → ERR; timeout[c] = en[c] & ~ackl[c].
- IN_SREF:
  - app_sref_req held = en.
  - app_mem_init_skip = app_xsdb_select = en.
  - status[5] = en.
  - sref_exit → EXIT_WAIT; sref_enter is ignored.
- EXIT_WAIT:
  - sref_req drops to 0 on entry; mem_init_skip and xsdb_select held.
  - Waits for init_calib_complete high simultaneously on all enabled channels → RESTORE.
  - Counter reaches CALIB_TIMEOUT → ERR; timeout[c] = en[c] & ~calib[c].
- RESTORE:
  - app_restore_complete = en for exactly RESTORE_HOLD cycles.
  - Then all app_* outputs go to 0 → IDLE, with done pulse.
- ERR:
  - One cycle: all app_* outputs 0; error=1; done pulse → IDLE.
  - Timeout flags remain until the next accepted sref_enter.
- Counters:
  - width $clog2(max timeout+1); cleared on each state entry; saturate, never wrap.
- NUM_CH=1 must work; en=0 everywhere makes ENTER complete in one cycle.

Test Plan:
- NUM_CH=3, en=3'b111; acks return after 5/9/12 cycles → req=111 from cycle 1; IN_SREF at ack+1; done pulse; status[c][5]=1, [3]=1, [0]=1.
- en=3'b101 → ch1 outputs stay 0; ch1 ack ignored; IN_SREF reached when ch0 and ch2 ack.
- ACK_TIMEOUT=20; ch2 never acks → ERR at cycle 20; error=1; status[2][6]=1; req=000; done pulse; next sref_enter clears error.
- From IN_SREF, sref_exit; calib rises at 30/40/50 → req drops; restore_complete=111 for exactly 16 cycles starting after cycle 50; then IDLE; done pulse; all outputs 0.
- Stress:
  - sref_enter and sref_exit in the same IDLE cycle → ENTER.
  - rst_main_n low mid-EXIT_WAIT → next cycle all outputs 0, state_o=0.
  - CALIB_TIMEOUT=30 with ch1 calib never rising → ERR, status[1][6]=1.
